// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Brief    : Multi-cycle 16-bit ALU sequencer driving an external 8x16
//            register file: read A, read B, execute, write back, done.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [1:0]  shift,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [2:0]  rd,
    input  logic [15:0] rf_data,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [15:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status
);

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_and = 2'b10;

    localparam logic [1:0] c_sh_none = 2'b00;
    localparam logic [1:0] c_sh_lsl  = 2'b01;
    localparam logic [1:0] c_sh_lsr  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  shift_q, shift_d;
    logic [2:0]  rn_q, rn_d;
    logic [2:0]  rm_q, rm_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] c_q, c_d;
    logic [2:0]  status_q, status_d;

    logic [15:0] w_bs;
    logic [15:0] w_res;
    logic        w_ovf;

    // Shifter feeding the ALU B input, then the ALU itself (carry discarded).
    always_comb begin
        case (shift_q)
            c_sh_none: w_bs = b_q;
            c_sh_lsl:  w_bs = {b_q[14:0], 1'b0};
            c_sh_lsr:  w_bs = {1'b0, b_q[15:1]};
            default:   w_bs = {b_q[15], b_q[15:1]};
        endcase

        w_ovf = 1'b0;
        case (op_q)
            c_op_add: begin
                w_res = a_q + w_bs;
                w_ovf = (a_q[15] == w_bs[15]) && (w_res[15] != a_q[15]);
            end
            c_op_sub: begin
                w_res = a_q - w_bs;
                w_ovf = (a_q[15] != w_bs[15]) && (w_res[15] != a_q[15]);
            end
            c_op_and: w_res = a_q & w_bs;
            default:  w_res = ~w_bs;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shift_d  = shift_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RDA;
                    op_d    = op;
                    shift_d = shift;
                    rn_d    = rn;
                    rm_d    = rm;
                    rd_d    = rd;
                end
            end
            S_RDA: begin
                a_d     = rf_data;
                state_d = S_RDB;
            end
            S_RDB: begin
                b_d     = rf_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d      = w_res;
                status_d = {w_ovf, w_res[15], (w_res == 16'h0000)};
                state_d  = S_WB;
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            shift_q  <= 2'b00;
            rn_q     <= 3'd0;
            rm_q     <= 3'd0;
            rd_q     <= 3'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            c_q      <= 16'h0000;
            status_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shift_q  <= shift_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    // Outputs are masked by reset_n so a reset landing in WB blocks that edge's write.
    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        data_in  = 16'h0000;
        if (reset_n) begin
            busy    = (state_q != S_IDLE);
            data_in = c_q;
            case (state_q)
                S_RDA:   readnum = rn_q;
                S_RDB:   readnum = rm_q;
                S_WB: begin
                    write    = 1'b1;
                    writenum = rd_q;
                end
                S_DONE:  done = 1'b1;
                default: readnum = 3'd0;
            endcase
        end
    end

    assign status = status_q;

endmodule
`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock shared with the 8x16 register file.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 op  input  2  ALU op: 00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B (A ignored).
REQ-006 shift  input  2  B-operand shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (sign fill).
REQ-007 rn, rm, rd  input  3 each  source-A, source-B and destination register numbers.
REQ-008 rf_data  input  16  register-file read data; combinational function of readnum.
REQ-009 readnum  output  3  register-file read select.
REQ-010 writenum  output  3  register-file write select.
REQ-011 write  output  1  register-file write enable; the file writes data_in at rising clk when write=1.
REQ-012 data_in  output  16  register-file write data; always equal to result register C.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 status  output  3  {V,N,Z} flags of the last executed op.

Function
REQ-016 FSM states SHALL be IDLE, RDA, RDB, EXEC, WB and DONE; each non-IDLE state SHALL last exactly one cycle.
REQ-017 Transitions SHALL be: IDLE->RDA when start=1, else stay in IDLE; then RDA->RDB->EXEC->WB->DONE->IDLE unconditionally.
REQ-018 On the IDLE->RDA edge, op, shift, rn, rm and rd SHALL be latched; later input changes SHALL have no effect on the operation in flight.
REQ-019 start SHALL be ignored in every state other than IDLE, so back-to-back requests are separated by at least one IDLE cycle.
REQ-020 readnum SHALL equal latched rn in RDA, latched rm in RDB, and 0 otherwise.
REQ-021 Register A SHALL load rf_data at the end of RDA; register B SHALL load rf_data at the end of RDB.
REQ-022 In EXEC, Bs = shift(B); the ALU SHALL compute modulo-2^16 with carry-out discarded; C and status SHALL load at the end of EXEC only.
REQ-023 Z SHALL be 1 iff the 16-bit result is 0; N SHALL equal result[15].
REQ-024 V SHALL be the signed two's-complement overflow for ADD and SUB, and SHALL be 0 for AND and NOT.
REQ-025 In WB, write=1 and writenum=latched rd; in all other states write=0 and writenum=0.
REQ-026 done SHALL be 1 only in DONE, exactly 5 cycles after the edge that accepted start.
REQ-027 rd equal to rn or rm SHALL be legal; sources are read before WB, so the old register values are used.
REQ-028 ASR1 of 0x8000 SHALL give 0xC000; LSL1 of 0x8000 SHALL give 0x0000.

Reset
REQ-029 When reset_n=0 at a rising clk, the next state SHALL be IDLE, and A, B, C, status and latched fields SHALL be 0.
REQ-030 While in reset: write=0, done=0, busy=0, readnum=0, writenum=0, data_in=0.
REQ-031 Reset asserted in any state, including WB, SHALL abort the op; no register-file write SHALL occur on that edge or later.

Verification
REQ-032 R1=0x0005, R2=0x0003; start with op=ADD, shift=00, rn=1, rm=2, rd=3 -> write=1 with data_in=0x0008 in WB, done 5 cycles after acceptance, status=000.
REQ-033 R1=0x7FFF, R2=0x0001; ADD, rd=4 -> R4=0x8000, status V=1, N=1, Z=0; repeat with SUB and R1=R2 -> result 0x0000, Z=1.
REQ-034 R5=0x8000; op=NOT, shift=ASR1, rm=5, rd=5 -> Bs=0xC000, R5=0x3FFF, status=000.
REQ-035 Hold start=1 continuously and change rn mid-operation -> ops accepted only from IDLE, each uses the fields latched at acceptance, and at least 1 idle cycle separates done and the next RDA.
REQ-036 Assert reset_n=0 during the WB cycle -> the destination register is unchanged, state IDLE, all outputs 0 on the next cycle.
